// File: rtl/syndrome_sequencer.sv
// ============================================================================
//  Module      : syndrome_sequencer
//  Description : GF(2^5) syndrome stage controller for the RS(31,k) decoder.
//                Horner-accumulates NSYN syndromes over one received word,
//                then streams them out one per handshake.
//                Optional macro SYNDROME_ZERO_FLAG_EN adds the err_free output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module syndrome_sequencer #(
  parameter int NSYN = 4,
  parameter int NSYM = 31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_sym,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_sym,
  output logic [2:0] out_idx,
  output logic       busy
`ifdef SYNDROME_ZERO_FLAG_EN
  ,output logic      err_free
`endif
);

  localparam logic [4:0] c_LAST_SYM = 5'(NSYM - 1);
  localparam logic [2:0] c_LAST_SYN = 3'(NSYN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [4:0]            r_count;
  logic [2:0]            r_out_idx;
  logic [NSYN-1:0][4:0]  r_acc;
  logic [NSYN-1:0][4:0]  w_acc_step;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_last_sym;
  logic                  w_last_syn;

  // Multiply by alpha^n as n chained shifts with x^5 folded back into x^2 + 1.
  function automatic logic [4:0] f_mul_alpha_pow(input logic [4:0] x, input int n);
    logic [4:0] v;
    v = x;
    for (int i = 0; i < n; i++) begin
      v = {v[3], v[2], v[1] ^ v[4], v[0], v[4]};
    end
    return v;
  endfunction

  for (genvar j = 0; j < NSYN; j++) begin : g_acc
    assign w_acc_step[j] = f_mul_alpha_pow(r_acc[j], j + 1) ^ in_sym;
  end

  assign w_last_sym = (r_count == c_LAST_SYM);
  assign w_last_syn = (r_out_idx == c_LAST_SYN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    w_in_xfer    = 1'b0;
    w_out_xfer   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready  = 1'b1;
        w_in_xfer = in_valid;
        if (in_valid) begin
          w_state_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready  = 1'b1;
        busy      = 1'b1;
        w_in_xfer = in_valid;
        if (in_valid && w_last_sym) begin
          w_state_next = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        out_valid  = 1'b1;
        busy       = 1'b1;
        w_out_xfer = out_ready;
        if (out_ready && w_last_syn) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_out_idx <= '0;
      r_acc     <= '0;
    end else begin
      if (w_in_xfer) begin
        // First symbol both clears and seeds every accumulator.
        if (r_state == ST_IDLE) begin
          r_acc   <= {NSYN{in_sym}};
          r_count <= 5'd1;
        end else begin
          r_acc   <= w_acc_step;
          r_count <= r_count + 5'd1;
        end
      end
      if (w_out_xfer) begin
        if (w_last_syn) begin
          r_out_idx <= '0;
          r_count   <= '0;
        end else begin
          r_out_idx <= r_out_idx + 3'd1;
        end
      end
    end
  end

  always_comb begin
    out_sym = '0;
    if (r_state == ST_OUTPUT) begin
      for (int j = 0; j < NSYN; j++) begin
        if (r_out_idx == 3'(j)) begin
          out_sym = r_acc[j];
        end
      end
    end
  end

  assign out_idx = r_out_idx;

`ifdef SYNDROME_ZERO_FLAG_EN
  logic r_err_free;

  // Captured from the final accumulator update so it is valid on OUTPUT entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_free <= 1'b0;
    end else if (r_state == ST_ACCUM && w_in_xfer && w_last_sym) begin
      r_err_free <= (w_acc_step == '0);
    end else if (w_out_xfer && w_last_syn) begin
      r_err_free <= 1'b0;
    end
  end

  assign err_free = r_err_free;
`endif

endmodule

`default_nettype wire

// File: tb/tb_syndrome_sequencer.sv
// ============================================================================
//  Module      : tb_syndrome_sequencer
//  Description : Randomized self-checking bench for syndrome_sequencer against
//                a polynomial-evaluation model r(alpha^j).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_syndrome_sequencer;

  localparam int NSYN = 4;
  localparam int NSYM = 31;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_sym;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_sym;
  logic [2:0] out_idx;
  logic       busy;
`ifdef SYNDROME_ZERO_FLAG_EN
  logic       err_free;
`endif

  int checks   = 0;
  int failures = 0;

  logic [4:0] word    [NSYM];
  logic [4:0] exp_syn [NSYN];

  always #5 clock = ~clock;

  syndrome_sequencer #(
    .NSYN (NSYN),
    .NSYM (NSYM)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sym   (out_sym),
    .out_idx   (out_idx),
    .busy      (busy)
`ifdef SYNDROME_ZERO_FLAG_EN
    ,.err_free (err_free)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Generic shift-and-add GF(2^5) multiply, reduction polynomial 0b100101.
  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] aa;
    logic [4:0] p;
    aa = {1'b0, a};
    p  = '0;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) p = p ^ aa[4:0];
      aa = aa << 1;
      if (aa[5]) aa = aa ^ 6'b100101;
    end
    return p;
  endfunction

  function automatic logic [4:0] gf_pow(input logic [4:0] a, input int n);
    logic [4:0] r;
    r = 5'd1;
    for (int i = 0; i < n; i++) r = gf_mul(r, a);
    return r;
  endfunction

  // S_j = r(alpha^j); the first symbol sent is the degree NSYM-1 coefficient.
  task automatic compute_expected();
    logic [4:0] aj;
    for (int j = 1; j <= NSYN; j++) begin
      aj = gf_pow(5'd2, j);
      exp_syn[j-1] = '0;
      for (int i = 0; i < NSYM; i++) begin
        exp_syn[j-1] = exp_syn[j-1] ^ gf_mul(word[i], gf_pow(aj, NSYM - 1 - i));
      end
    end
  endtask

  task automatic send_word(input int n, input bit gaps);
    int i   = 0;
    int cyc = 0;
    bit v;
    while (i < n && cyc < 400) begin
      @(negedge clock);
      check("in_ready_accept", 32'(in_ready), 32'd1);
      check("out_valid_during_input", 32'(out_valid), 32'd0);
      check("busy_during_input", 32'(busy), (i != 0) ? 32'd1 : 32'd0);
      v        = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = v;
      in_sym   = v ? word[i] : 5'($urandom);
      if (v && in_ready) i++;
      cyc++;
    end
    if (i < n) check("send_timeout", 32'(i), 32'(n));
  endtask

  task automatic receive_word(input bit rand_ready, input int stall_idx);
    int k     = 0;
    int cyc   = 0;
    int stall = 0;
    bit rdy;
    bit allz  = 1'b1;
    for (int j = 0; j < NSYN; j++) if (exp_syn[j] != 5'd0) allz = 1'b0;
    while (k < NSYN && cyc < 200) begin
      @(negedge clock);
      check("out_valid", 32'(out_valid), 32'd1);
      check("in_ready_output", 32'(in_ready), 32'd0);
      check("busy_output", 32'(busy), 32'd1);
      check("out_idx", 32'(out_idx), 32'(k));
      check("out_sym", 32'(out_sym), 32'(exp_syn[k]));
`ifdef SYNDROME_ZERO_FLAG_EN
      check("err_free", 32'(err_free), 32'(allz));
`endif
      if (k == stall_idx && stall < 3) begin
        rdy = 1'b0;
        stall++;
      end else begin
        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      out_ready = rdy;
      in_valid  = 1'($urandom_range(0, 1));
      in_sym    = 5'($urandom);
      if (rdy && out_valid) k++;
      cyc++;
    end
    if (k < NSYN) check("recv_timeout", 32'(k), 32'(NSYN));
    @(negedge clock);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_idx", 32'(out_idx), 32'd0);
`ifdef SYNDROME_ZERO_FLAG_EN
    check("idle_err_free", 32'(err_free), 32'd0);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    check({tag, "_out_sym"}, 32'(out_sym), 32'd0);
`ifdef SYNDROME_ZERO_FLAG_EN
    check({tag, "_err_free"}, 32'(err_free), 32'd0);
`endif
  endtask

  task automatic set_word(input int mode);
    for (int i = 0; i < NSYM; i++) begin
      case (mode)
        0:       word[i] = 5'd0;
        1:       word[i] = (i == NSYM - 1) ? 5'd7 : 5'd0;
        2:       word[i] = (i == NSYM - 2) ? 5'd1 : 5'd0;
        3:       word[i] = (i == 0) ? 5'd1 : 5'd0;
        default: word[i] = 5'($urandom);
      endcase
    end
    compute_expected();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sym    = 5'd0;
    out_ready = 1'b0;
    @(negedge clock);
    check_reset_state("reset");
    reset = 1'b0;

    for (int m = 0; m < 4; m++) begin
      set_word(m);
      send_word(NSYM, 1'b0);
      receive_word(1'b0, -1);
    end

    for (int r = 0; r < 4; r++) begin
      set_word(9);
      send_word(NSYM, 1'b1);
      receive_word(1'b1, 1);
    end

    set_word(9);
    send_word(10, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset_state("midword_reset");
    @(negedge clock);
    reset = 1'b0;
    set_word(1);
    send_word(NSYM, 1'b1);
    receive_word(1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/syndrome_sequencer.md
Name: syndrome_sequencer

Overview:
- Controller for the GF(2^5) syndrome stage of the RS(31,k) decoder.
- Accepts one 31-symbol received word, serially and highest-degree coefficient first, over a valid/ready handshake.
- Runs NSYN Horner accumulators in parallel: S_j <= S_j*alpha^j + r, for j = 1..NSYN.
- Then streams the syndromes out one per handshake to the key-equation solver.
- Field: GF(2^5), p(x) = x^5 + x^2 + 1, alpha = 5'b00010, bit 0 = LSB.

Parameters:
- NSYN, 4, number of syndromes computed (2T). Legal range 1..8.
- NSYM, 31, symbols per codeword. Legal range 2..31.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  received symbol valid.
- in_ready  out  1  block can accept a symbol.
- in_sym  in  5  received symbol.
- out_valid  out  1  syndrome valid.
- out_ready  in  1  downstream accepts the syndrome.
- out_sym  out  5  syndrome value S_(out_idx+1).
- out_idx  out  3  syndrome index, 0-based.
- busy  out  1  high in ACCUM or OUTPUT.

Behaviour:
- Reset (async): state=IDLE, sym count=0, all accumulators=0, in_ready=1, out_valid=0, out_sym=0, out_idx=0, busy=0.
- Input transfer = in_valid & in_ready, sampled at the clock edge. Output transfer = out_valid & out_ready.
- States: IDLE, ACCUM, OUTPUT.
- IDLE:
  - in_ready=1.
  - On an input transfer: acc_j <= in_sym for all j (the accumulator clear and first Horner step are fused), count <= 1, go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On each transfer: acc_j <= gfmul(acc_j, alpha^j) XOR in_sym, count <= count+1.
  - The transfer with count==NSYM-1 (the NSYM-th symbol) updates the accumulators and moves to OUTPUT.
  - No transfer: hold all state. Gaps in in_valid are allowed.
- OUTPUT:
  - in_ready=0, out_valid=1, out_sym=acc[out_idx] (combinational mux from the registered accumulators).
  - On each output transfer, out_idx increments.
  - The transfer at out_idx==NSYN-1 sets out_idx <= 0, count <= 0, and returns to IDLE.
  - While out_ready=0, out_sym and out_idx stay stable.
- Latency: the first syndrome is valid on the cycle after the NSYM-th input transfer.
- Back-to-back words: a new word is accepted only in IDLE. There is no overlap with OUTPUT, so input and output transfers are never simultaneous.
- Accumulators hold their values after OUTPUT until the next word's first symbol.
- Constant multipliers alpha^1..alpha^5 = 2, 4, 8, 16, 5, i.e. successive multiply-by-alpha with the reduction x^5 -> x^2 + 1. Implement as fixed XOR networks or as a shared GF(2^5) multiplier instance per accumulator. All arithmetic is 5-bit with no carries.
- busy=1 exactly when state != IDLE.
- Reset asserted mid-word or mid-output: immediate return to the reset state. The partial word is discarded and no syndrome is emitted.

Optional Feature:
- Macro: SYNDROME_ZERO_FLAG_EN.
- When defined, an extra output port err_free (1 bit) exists.
  - err_free is registered and valid throughout OUTPUT.
  - It is 1 iff all NSYN accumulators equal 0 at entry to OUTPUT.
  - It resets to 0 and clears to 0 on return to IDLE.
  - OUTPUT still streams all NSYN syndromes.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- All-zero word, 31 symbols of 0, out_ready=1 -> four transfers: out_sym=0 at idx 0..3; err_free=1 with the macro; busy falls after idx 3.
- Symbols 1..30 = 0, symbol 31 = 7 -> out_sym = 7, 7, 7, 7.
- Symbol 30 = 1, all others 0 -> out_sym = 2, 4, 8, 16 (alpha^j).
- Symbol 1 = 1, all others 0 -> S_1 = alpha^30 = 18 (5'b10010); err_free=0.
- Random in_valid gaps plus out_ready held low for 3 cycles at idx 1 -> syndromes match the gap-free run; out_sym and out_idx stable while stalled; in_ready=0 throughout OUTPUT.
- reset pulsed after 10 input symbols, then a fresh word with symbol 31 = 7 -> out_valid never asserted before the fresh word; then 7, 7, 7, 7.
